// File: rtl/id_ex_stage_pkg.sv
// id_ex_defs: shared widths, ALU op bit indices, operand select encodings and the EX bundle
package id_ex_defs;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 20;
    localparam int REG_AW = 5;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;
    localparam int ALU_MUL  = 12;
    localparam int ALU_MULH = 13;
    localparam int ALU_MULHU = 14;
    localparam int ALU_DIV  = 15;
    localparam int ALU_MOD  = 16;
    localparam int ALU_DIVU = 17;
    localparam int ALU_BEQ  = 18;
    localparam int ALU_BNEQ = 19;

    typedef enum logic [1:0] {
        SRC1_RS   = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_SA   = 2'd2,
        SRC1_ZERO = 2'd3
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RT    = 2'd0,
        SRC2_SIMM  = 2'd1,
        SRC2_ZIMM  = 2'd2,
        SRC2_EIGHT = 2'd3
    } src2_sel_e;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [CTRL_W-1:0] alu_op;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [15:0]       imm;
        logic [4:0]        sa;
        src1_sel_e         src1_sel;
        src2_sel_e         src2_sel;
        logic [REG_AW-1:0] dest;
        logic              gr_we;
        logic              mem_we;
        logic              res_from_mem;
    } es_bundle_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-to-EX bundle, EX-to-MEM side-band, ALU drive and ID bypass/hazard taps
interface id_ex_stage_if;
    import id_ex_defs::*;

    logic              ds_to_es_valid;
    logic              es_allowin;
    logic [DATA_W-1:0] ds_pc;
    logic [CTRL_W-1:0] ds_alu_op;
    logic [DATA_W-1:0] ds_rs_val;
    logic [DATA_W-1:0] ds_rt_val;
    logic [15:0]       ds_imm;
    logic [4:0]        ds_sa;
    logic [1:0]        ds_src1_sel;
    logic [1:0]        ds_src2_sel;
    logic [REG_AW-1:0] ds_dest;
    logic              ds_gr_we;
    logic              ds_mem_we;
    logic              ds_res_from_mem;
    logic              flush;
    logic              ms_allowin;
    logic              es_to_ms_valid;
    logic [CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [DATA_W-1:0] es_pc;
    logic [REG_AW-1:0] es_dest;
    logic              es_gr_we;
    logic              es_mem_we;
    logic              es_res_from_mem;
    logic [DATA_W-1:0] es_rt_val;
    logic              es_fwd_valid;
    logic [REG_AW-1:0] es_fwd_dest;
    logic              es_fwd_is_load;

    modport master (
        output ds_to_es_valid, ds_pc, ds_alu_op, ds_rs_val, ds_rt_val, ds_imm, ds_sa,
               ds_src1_sel, ds_src2_sel, ds_dest, ds_gr_we, ds_mem_we, ds_res_from_mem,
               flush, ms_allowin,
        input  es_allowin, es_to_ms_valid, alu_control, alu_src1, alu_src2, es_pc, es_dest,
               es_gr_we, es_mem_we, es_res_from_mem, es_rt_val, es_fwd_valid, es_fwd_dest,
               es_fwd_is_load
    );

    modport slave (
        input  ds_to_es_valid, ds_pc, ds_alu_op, ds_rs_val, ds_rt_val, ds_imm, ds_sa,
               ds_src1_sel, ds_src2_sel, ds_dest, ds_gr_we, ds_mem_we, ds_res_from_mem,
               flush, ms_allowin,
        output es_allowin, es_to_ms_valid, alu_control, alu_src1, alu_src2, es_pc, es_dest,
               es_gr_we, es_mem_we, es_res_from_mem, es_rt_val, es_fwd_valid, es_fwd_dest,
               es_fwd_is_load
    );

endinterface

// File: rtl/id_ex_stage_operand_mux.sv
// ex_operand_mux: forms both ALU operands from the registered EX fields
module ex_operand_mux
    import id_ex_defs::*;
(
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rs_val_i,
    input  logic [DATA_W-1:0] rt_val_i,
    input  logic [15:0]       imm_i,
    input  logic [4:0]        sa_i,
    input  src1_sel_e         src1_sel_i,
    input  src2_sel_e         src2_sel_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o
);

    // Shift amount goes on src1 because the ALU shifts src2 by src1[4:0]; constant 8 pairs with pc for link addresses
    always_comb begin
        alu_src1_o = src1_sel_i == SRC1_RS ? rs_val_i :
                     src1_sel_i == SRC1_PC ? pc_i :
                     src1_sel_i == SRC1_SA ? {{(DATA_W-5){1'b0}}, sa_i} : '0;
        alu_src2_o = src2_sel_i == SRC2_RT   ? rt_val_i :
                     src2_sel_i == SRC2_SIMM ? {{(DATA_W-16){imm_i[15]}}, imm_i} :
                     src2_sel_i == SRC2_ZIMM ? {{(DATA_W-16){1'b0}}, imm_i} : DATA_W'(8);
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with valid/allow-in handshake, operand formation and bypass taps
module id_ex_stage
    import id_ex_defs::*;
(
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    es_bundle_t bundle_q, bundle_d, ds_bundle;
    logic       es_valid_q, es_valid_d;
    logic       es_ready_go, allowin, load_en;

    // Single-cycle combinational ALU, so EX is always ready to hand off
    assign es_ready_go = 1'b1;
    assign allowin     = !es_valid_q | (es_ready_go & bus.ms_allowin);

    assign ds_bundle = '{
        pc:           bus.ds_pc,
        alu_op:       bus.ds_alu_op,
        rs_val:       bus.ds_rs_val,
        rt_val:       bus.ds_rt_val,
        imm:          bus.ds_imm,
        sa:           bus.ds_sa,
        src1_sel:     src1_sel_e'(bus.ds_src1_sel),
        src2_sel:     src2_sel_e'(bus.ds_src2_sel),
        dest:         bus.ds_dest,
        gr_we:        bus.ds_gr_we,
        mem_we:       bus.ds_mem_we,
        res_from_mem: bus.ds_res_from_mem
    };

    // Flush kills both the held instruction and any incoming one; fields hold whenever nothing is captured
    always_comb begin
        load_en    = bus.ds_to_es_valid & allowin & !bus.flush;
        es_valid_d = bus.flush ? 1'b0 : allowin ? bus.ds_to_es_valid : es_valid_q;
        bundle_d   = load_en ? ds_bundle : bundle_q;
    end

    // Pipeline state register
    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            bundle_q   <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bundle_q   <= bundle_d;
        end
    end

    ex_operand_mux u_mux (
        .pc_i       (bundle_q.pc),
        .rs_val_i   (bundle_q.rs_val),
        .rt_val_i   (bundle_q.rt_val),
        .imm_i      (bundle_q.imm),
        .sa_i       (bundle_q.sa),
        .src1_sel_i (bundle_q.src1_sel),
        .src2_sel_i (bundle_q.src2_sel),
        .alu_src1_o (bus.alu_src1),
        .alu_src2_o (bus.alu_src2)
    );

    assign bus.es_allowin      = allowin;
    assign bus.es_to_ms_valid  = es_valid_q & es_ready_go;
    assign bus.alu_control     = es_valid_q ? bundle_q.alu_op : '0;
    assign bus.es_pc           = bundle_q.pc;
    assign bus.es_dest         = bundle_q.dest;
    assign bus.es_gr_we        = bundle_q.gr_we;
    assign bus.es_mem_we       = bundle_q.mem_we;
    assign bus.es_res_from_mem = bundle_q.res_from_mem;
    assign bus.es_rt_val       = bundle_q.rt_val;
    assign bus.es_fwd_valid    = es_valid_q & bundle_q.gr_we & (bundle_q.dest != '0);
    assign bus.es_fwd_dest     = bundle_q.dest;
    assign bus.es_fwd_is_load  = es_valid_q & bundle_q.res_from_mem;

endmodule
